sna_req_tx: RTL and testbench

Parametrised request transmitter of the slave network adapter (SNA): it takes request packets (header, address and, for writes, data flits) from the NoC receive path and issues them on the AXI4-Lite AW/W/AR channels with full valid/ready handshakes. It records the requesting node address of every issued request in per-direction tag FIFOs, which the SNA response path pops to route B/R responses back. It sits between the SNA flit receive buffer and the AXI4-Lite slave port.

---
 rtl/sna_req_tx.sv | 181 ++++++++++++++++++
 tb/tb_sna_req_tx.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sna_req_tx.sv
// SNA request transmitter: turns NoC request packets into AXI4-Lite AW/W/AR transfers and
// queues each requester's node id in per-direction tag FIFOs. Optional macro: SNA_WSTRB_EN.

module sna_tag_fifo #(
    parameter int NODE_W = 4,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [NODE_W-1:0] push_tag,
    input  logic              pop,
    output logic [NODE_W-1:0] head,
    output logic              valid,
    output logic              full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [NODE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_pop = pop && (count != '0);
    assign valid  = (count != '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign head   = valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_tag;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) rd_ptr <= next_ptr(rd_ptr);
            if (push && !do_pop)      count <= count + CNT_W'(1);
            else if (!push && do_pop) count <= count - CNT_W'(1);
        end
    end
endmodule

module sna_req_tx #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int NODE_W    = 4,
    parameter int FLIT_W    = 32,
    parameter int TAG_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [FLIT_W-1:0]   flit_data,
    input  logic                flit_valid,
    output logic                flit_ready,
    output logic                busy,
    output logic [2:0]          dbg_state,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    output logic [ADDR_W-1:0]   araddr,
    output logic                arvalid,
    input  logic                arready,
    output logic [NODE_W-1:0]   wr_tag,
    output logic                wr_tag_valid,
    input  logic                wr_tag_pop,
    output logic [NODE_W-1:0]   rd_tag,
    output logic                rd_tag_valid,
    input  logic                rd_tag_pop
);
    localparam int STRB_W = DATA_W / 8;

    // Handshake rule on every channel: a transfer happens on a rising edge where valid and
    // ready are both high; a raised valid holds its payload until then and never looks at ready.
    typedef enum logic [2:0] {S_HDR, S_ADDR, S_DATA, S_ISSUE_W, S_ISSUE_R} state_t;

    state_t            state_q, state_d;
    logic              is_write;
    logic [NODE_W-1:0] src_node;
    logic              aw_done, w_done;
    logic              flit_hs, aw_hs, w_hs, ar_hs;
    logic              issue_w, wr_push, rd_push;
    logic              wr_full, rd_full;
    logic              unused_flit;

    assign unused_flit = ^flit_data;
    assign dbg_state   = state_q;
    assign busy        = (state_q != S_HDR);
    assign flit_ready  = rst_n && (state_q == S_HDR || state_q == S_ADDR || state_q == S_DATA);
    assign flit_hs     = flit_valid && flit_ready;

    // Tag FIFO space is only consumed by our own pushes, so once a valid rises it stays up.
    assign issue_w = (state_q == S_ISSUE_W);
    assign awvalid = issue_w && !aw_done && !wr_full;
    assign wvalid  = issue_w && !w_done && !wr_full;
    assign arvalid = (state_q == S_ISSUE_R) && !rd_full;
    assign aw_hs   = awvalid && awready;
    assign w_hs    = wvalid && wready;
    assign ar_hs   = arvalid && arready;
    assign wr_push = issue_w && (aw_done || aw_hs) && (w_done || w_hs);
    assign rd_push = ar_hs;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HDR:     if (flit_hs) state_d = S_ADDR;
            S_ADDR:    if (flit_hs) state_d = is_write ? S_DATA : S_ISSUE_R;
            S_DATA:    if (flit_hs) state_d = S_ISSUE_W;
            S_ISSUE_W: if (wr_push) state_d = S_HDR;
            S_ISSUE_R: if (rd_push) state_d = S_HDR;
            default:   state_d = S_HDR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_HDR;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_write <= 1'b0;
            src_node <= '0;
            awaddr   <= '0;
            araddr   <= '0;
            wdata    <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            if (state_q == S_HDR && flit_hs) begin
                is_write <= flit_data[0];
                src_node <= flit_data[NODE_W:1];
            end
            if (state_q == S_ADDR && flit_hs) begin
                if (is_write) awaddr <= flit_data[ADDR_W-1:0];
                else          araddr <= flit_data[ADDR_W-1:0];
            end
            if (state_q == S_DATA && flit_hs) wdata <= flit_data[DATA_W-1:0];
            if (wr_push) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else if (issue_w) begin
                aw_done <= aw_done || aw_hs;
                w_done  <= w_done || w_hs;
            end
        end
    end

`ifdef SNA_WSTRB_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                         wstrb <= '1;
        else if (state_q == S_HDR && flit_hs) wstrb <= flit_data[NODE_W+STRB_W:NODE_W+1];
    end
`else
    assign wstrb = '1;
`endif

    sna_tag_fifo #(.NODE_W(NODE_W), .DEPTH(TAG_DEPTH)) u_wr_tags (
        .clk(clk), .rst_n(rst_n), .push(wr_push), .push_tag(src_node), .pop(wr_tag_pop),
        .head(wr_tag), .valid(wr_tag_valid), .full(wr_full)
    );

    sna_tag_fifo #(.NODE_W(NODE_W), .DEPTH(TAG_DEPTH)) u_rd_tags (
        .clk(clk), .rst_n(rst_n), .push(rd_push), .push_tag(src_node), .pop(rd_tag_pop),
        .head(rd_tag), .valid(rd_tag_valid), .full(rd_full)
    );
endmodule

// File: tb/tb_sna_req_tx.sv
// Bench for sna_req_tx: directed timing cases plus a random phase, all checked through
// expected queues of AXI payloads and tags filled as packets are sent.

module tb_sna_req_tx;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int NODE_W    = 4;
    localparam int FLIT_W    = 32;
    localparam int TAG_DEPTH = 4;
    localparam int STRB_W    = DATA_W / 8;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [FLIT_W-1:0]   flit_data;
    logic                flit_valid;
    logic                flit_ready;
    logic                busy;
    logic [2:0]          dbg_state;
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready = 1'b0;
    logic [DATA_W-1:0]   wdata;
    logic [STRB_W-1:0]   wstrb;
    logic                wvalid;
    logic                wready = 1'b0;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready = 1'b0;
    logic [NODE_W-1:0]   wr_tag;
    logic                wr_tag_valid;
    logic                wr_tag_pop = 1'b0;
    logic [NODE_W-1:0]   rd_tag;
    logic                rd_tag_valid;
    logic                rd_tag_pop = 1'b0;

    sna_req_tx #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NODE_W(NODE_W), .FLIT_W(FLIT_W),
                 .TAG_DEPTH(TAG_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flit_data(flit_data), .flit_valid(flit_valid),
        .flit_ready(flit_ready), .busy(busy), .dbg_state(dbg_state),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .wr_tag(wr_tag), .wr_tag_valid(wr_tag_valid), .wr_tag_pop(wr_tag_pop),
        .rd_tag(rd_tag), .rd_tag_valid(rd_tag_valid), .rd_tag_pop(rd_tag_pop)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [ADDR_W-1:0]        exp_aw_q[$];
    logic [STRB_W+DATA_W-1:0] exp_w_q[$];
    logic [ADDR_W-1:0]        exp_ar_q[$];
    logic [NODE_W-1:0]        exp_wtag_q[$];
    logic [NODE_W-1:0]        exp_rtag_q[$];

    int aw_delay = 0, w_delay = 0, ar_delay = 0;
    int pop_mode = 0;
    bit force_rd = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [STRB_W-1:0] exp_strb(input logic [STRB_W-1:0] s);
`ifdef SNA_WSTRB_EN
        return s;
`else
        return s | {STRB_W{1'b1}};
`endif
    endfunction

    function automatic logic [FLIT_W-1:0] mk_hdr(input bit wr, input logic [NODE_W-1:0] node,
                                                 input logic [STRB_W-1:0] strb);
        logic [FLIT_W-1:0] h;
        h = '0;
        h[0] = wr;
        h[NODE_W:1] = node;
        h[NODE_W+STRB_W:NODE_W+1] = strb;
        return h;
    endfunction

    // ---------------- ready responders: ready after <delay> cycles of valid ----------------
    initial begin
        int aw_cnt, w_cnt, ar_cnt;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (awvalid) begin awready = (aw_cnt >= aw_delay); aw_cnt++; end
            else begin awready = 1'b0; aw_cnt = 0; end
            if (wvalid) begin wready = (w_cnt >= w_delay); w_cnt++; end
            else begin wready = 1'b0; w_cnt = 0; end
            if (arvalid) begin arready = (ar_cnt >= ar_delay); ar_cnt++; end
            else begin arready = 1'b0; ar_cnt = 0; end
        end
    end

    // ---------------- tag poppers ----------------
    initial begin
        forever begin
            @(posedge clk); #2;
            case (pop_mode)
                2: begin wr_tag_pop = wr_tag_valid; rd_tag_pop = rd_tag_valid; end
                1: begin
                    wr_tag_pop = ($urandom_range(0, 2) == 0);
                    rd_tag_pop = ($urandom_range(0, 2) == 0);
                end
                default: begin wr_tag_pop = 1'b0; rd_tag_pop = force_rd; end
            endcase
        end
    end

    // ---------------- monitor ----------------
    initial begin
        bit aw_pend, w_pend, ar_pend;
        logic [ADDR_W-1:0] aw_prev, ar_prev;
        logic [STRB_W+DATA_W-1:0] w_prev;
        aw_pend = 0; w_pend = 0; ar_pend = 0;
        aw_prev = '0; ar_prev = '0; w_prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                aw_pend = 0; w_pend = 0; ar_pend = 0;
            end else begin
                if (aw_pend) check("aw_hold", {awvalid, awaddr}, {1'b1, aw_prev});
                if (w_pend)  check("w_hold", {wvalid, wstrb, wdata}, {1'b1, w_prev});
                if (ar_pend) check("ar_hold", {arvalid, araddr}, {1'b1, ar_prev});
                if (awvalid && awready) begin
                    if (exp_aw_q.size() == 0) check("aw_unexp", 1, 0);
                    else check("aw_addr", awaddr, exp_aw_q.pop_front());
                end
                if (wvalid && wready) begin
                    if (exp_w_q.size() == 0) check("w_unexp", 1, 0);
                    else check("w_strb_data", {wstrb, wdata}, exp_w_q.pop_front());
                end
                if (arvalid && arready) begin
                    if (exp_ar_q.size() == 0) check("ar_unexp", 1, 0);
                    else check("ar_addr", araddr, exp_ar_q.pop_front());
                end
                if (wr_tag_pop && wr_tag_valid) begin
                    if (exp_wtag_q.size() == 0) check("wtag_unexp", 1, 0);
                    else check("wr_tag", wr_tag, exp_wtag_q.pop_front());
                end
                if (rd_tag_pop && rd_tag_valid) begin
                    if (exp_rtag_q.size() == 0) check("rtag_unexp", 1, 0);
                    else check("rd_tag", rd_tag, exp_rtag_q.pop_front());
                end
                aw_pend = awvalid && !awready; aw_prev = awaddr;
                w_pend  = wvalid && !wready;   w_prev  = {wstrb, wdata};
                ar_pend = arvalid && !arready; ar_prev = araddr;
            end
        end
    end

    // ---------------- driver tasks (enter and leave just after a rising edge) ----------------
    task automatic send_flit(input logic [FLIT_W-1:0] d);
        int n;
        bit ok;
        flit_valid = 1'b1;
        flit_data  = d;
        n = 0; ok = 0;
        while (!ok && n < 200) begin
            @(negedge clk); ok = flit_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!ok) check("flit_timeout", 0, 1);
    endtask

    task automatic send_packet(input bit wr, input logic [NODE_W-1:0] node,
                               input logic [STRB_W-1:0] strb, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] data);
        if (wr) begin
            exp_aw_q.push_back(addr);
            exp_w_q.push_back({exp_strb(strb), data});
            exp_wtag_q.push_back(node);
        end else begin
            exp_ar_q.push_back(addr);
            exp_rtag_q.push_back(node);
        end
        send_flit(mk_hdr(wr, node, strb));
        send_flit(FLIT_W'(addr));
        if (wr) send_flit(FLIT_W'(data));
        flit_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 1000) begin @(negedge clk); n++; end
        if (busy) check("idle_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        pop_mode = 2;
        repeat (2 * TAG_DEPTH + 2) @(posedge clk);
        pop_mode = 0;
        @(negedge clk);
        check("wtag_empty", wr_tag_valid, 0);
        check("rtag_empty", rd_tag_valid, 0);
        check("wtag_left", exp_wtag_q.size(), 0);
        check("rtag_left", exp_rtag_q.size(), 0);
        check("axi_left", exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size(), 0);
        @(posedge clk); #1;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0; flit_valid = 1'b0; flit_data = '0;
        repeat (2) @(posedge clk); #1;
        check("rst_flit_ready", flit_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_valids", {awvalid, wvalid, arvalid}, 0);
        check("rst_payload", {awaddr, araddr, wdata}, 0);
        check("rst_wstrb", wstrb, 4'hF);
        check("rst_tags", {wr_tag_valid, rd_tag_valid, wr_tag, rd_tag}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("hdr_ready", flit_ready, 1);
        @(posedge clk); #1;

        // write without stalls: issue in cycle 3, tag visible the cycle after the handshake
        send_packet(1, 4'd8, 4'b0001, 32'h1000_0040, 32'hDEAD_BEEF);
        @(negedge clk);
        check("w1_valids", {awvalid, wvalid}, 2'b11);
        check("w1_awaddr", awaddr, 32'h1000_0040);
        check("w1_wdata", wdata, 32'hDEAD_BEEF);
        check("w1_flit_ready", flit_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check("w1_done", {busy, awvalid, wvalid}, 0);
        check("w1_tag", {wr_tag_valid, wr_tag}, {1'b1, 4'd8});
        @(posedge clk); #1;
        drain();

        // read with arready 3 cycles late
        ar_delay = 3;
        send_packet(0, 4'd3, 4'b0000, 32'h2000_0000, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("r2_arvalid", arvalid, 1);
            check("r2_araddr", araddr, 32'h2000_0000);
            check("r2_flit_ready", flit_ready, 0);
            check("r2_no_tag", rd_tag_valid, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("r2_done", {busy, arvalid}, 0);
        check("r2_tag", {rd_tag_valid, rd_tag}, {1'b1, 4'd3});
        @(posedge clk); #1;
        ar_delay = 0;
        drain();

        // split W/AW: W accepted in cycle 3, AW in cycle 6, one tag push
        aw_delay = 3; w_delay = 0;
        send_packet(1, 4'd5, 4'b1111, 32'h0000_1234, 32'h5555_AAAA);
        @(negedge clk);
        check("s3_c3", {awvalid, wvalid}, 2'b11);
        for (int k = 4; k <= 6; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("s3_held", {awvalid, wvalid, wr_tag_valid, busy}, 4'b1001);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("s3_done", {awvalid, wvalid, busy}, 0);
        check("s3_tag", {wr_tag_valid, wr_tag}, {1'b1, 4'd5});
        @(posedge clk); #1;
        aw_delay = 0;
        drain();

        // tag FIFO full: the fifth read waits for a pop; order kept across the wrap
        for (int i = 0; i <= TAG_DEPTH; i++)
            send_packet(0, NODE_W'(i + 1), 4'b0, ADDR_W'(32'h3000_0000 + i * 4), 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("f4_blocked", {arvalid, busy, rd_tag_valid}, 3'b011);
            @(posedge clk); #1;
        end
        force_rd = 1'b1;
        @(negedge clk);
        check("f4_still_blocked", arvalid, 0);
        @(posedge clk); #1 force_rd = 1'b0;
        @(negedge clk);
        check("f4_issue", arvalid, 1);
        @(posedge clk); #1;
        wait_idle();
        drain();

        // strobe field: honoured only when the option is built in
        send_packet(1, 4'd2, 4'b0101, 32'h0000_0100, 32'h0102_0304);
        @(negedge clk);
        check("t5_wstrb", wstrb, exp_strb(4'b0101));
        @(posedge clk); #1;
        wait_idle();
        drain();

        // reset in the middle of a write packet
        send_packet(0, 4'd6, 4'b0, 32'h0000_0200, 32'h0);
        wait_idle();
        send_flit(mk_hdr(1, 4'd7, 4'b0011));
        send_flit(FLIT_W'(32'h0000_0300));
        flit_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_state", {busy, flit_ready, rd_tag_valid}, 3'b111);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check("rst_mid_valids", {awvalid, wvalid, arvalid, busy, flit_ready}, 0);
        check("rst_mid_fifos", {wr_tag_valid, rd_tag_valid, rd_tag}, 0);
        check("rst_mid_payload", {awaddr, wstrb}, {32'h0, 4'hF});
        exp_aw_q.delete(); exp_w_q.delete(); exp_ar_q.delete();
        exp_wtag_q.delete(); exp_rtag_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        send_packet(1, 4'd9, 4'b1000, 32'h0000_0400, 32'hCAFE_F00D);
        send_packet(0, 4'd10, 4'b0, 32'h0000_0500, 32'h0);
        wait_idle();
        drain();

        // random traffic with random stalls and random pops (including pops of empty FIFOs)
        pop_mode = 1;
        for (int i = 0; i < 40; i++) begin
            aw_delay = $urandom_range(0, 3);
            w_delay  = $urandom_range(0, 3);
            ar_delay = $urandom_range(0, 3);
            send_packet($urandom_range(0, 1), NODE_W'($urandom_range(0, 15)),
                        STRB_W'($urandom_range(0, 15)), $urandom, $urandom);
        end
        wait_idle();
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
